elevator_request_queue: RTL and testbench
=========================================

Name: elevator_request_queue

Overview:
- Request side of the car interface: latches floor-call buttons into a per-floor pending bitmap and clears entries as the car disembarks.
- Decides the service direction with a LOOK-style scan and drives queue_status, queue_empty and next_up_ndown to the car controller.
- Consumes current_floor, current_up_ndown and deassert_floor from the car. Sits between the button panel and the car model.

Parameters:
- NUM_FLOORS, 7, number of served floors (0..NUM_FLOORS-1)
- FLOOR_W, 3, width of the floor index

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- floor_button  input  NUM_FLOORS  raw call buttons, asynchronous to clk, one bit per floor
- current_floor  input  FLOOR_W  car position
- current_up_ndown  input  1  car travel direction (1=up)
- deassert_floor  input  1  car disembarking at current_floor (level)
- queue_status  output  NUM_FLOORS  pending request bitmap, bit i = floor i
- queue_empty  output  1  high when queue_status == 0
- next_up_ndown  output  1  direction the car takes on its next PREPARE TO MOVE (1=up)
- request_ack  output  NUM_FLOORS  one-cycle pulse per floor when a new request is latched

Behaviour:
- Interface decision: one clock, clk; reset_n is asynchronous and active-low. All flops clear immediately on reset_n low.
- Reset values:
  - queue_status = 0, queue_empty = 1, next_up_ndown = 1, request_ack = 0.
  - FSM = IDLE; synchronizer and edge flops = 0.
- Input path: each floor_button bit passes through a 2-FF synchronizer followed by a rising-edge detector (sync2 & ~prev).
  - A press meeting setup before clk edge k sets its queue_status bit after edge k+2. request_ack pulses in the same cycle the bit first reads 1.
  - A button held through reset release counts as one press.
  - Holding a button produces exactly one request.
- Bitmap update, evaluated per bit each cycle:
  - Set when an edge is detected.
  - Clear when deassert_floor=1 and i == current_floor.
  - Set and clear on the same bit in the same cycle: clear wins, and no request_ack is raised.
  - A press on an already-pending floor: no change, no request_ack.
- queue_empty is combinational NOR of the registered queue_status, so it has no extra latency.
- Masks, combinational:
  - above = pending bits with index > current_floor.
  - below = pending bits with index < current_floor.
  - current_floor >= NUM_FLOORS: above = 0, below = all pending.
- Direction FSM (dir_state_t), registered, evaluated every cycle:
  - IDLE:
    - If above != 0 and (below == 0 or current_up_ndown) -> UP.
    - Else if below != 0 -> DOWN.
    - Else stay.
  - UP:
    - If above != 0, stay.
    - Else if below != 0 -> DOWN.
    - Else if queue_empty -> IDLE.
    - Else stay (only current floor pending).
  - DOWN:
    - If below != 0, stay.
    - Else if above != 0 -> UP.
    - Else if queue_empty -> IDLE.
    - Else stay.
- next_up_ndown: registered; 1 in UP, 0 in DOWN, holds its last value in IDLE. It updates the cycle after the state transition.
- Reset mid-operation: all pending requests are discarded. Presses must be repeated after reset_n rises, except held buttons, which re-register.

Decomposition:
- Package elevator_pkg:
  - NUM_FLOORS and FLOOR_W constants.
  - typedef enum logic [1:0] dir_state_t {IDLE, UP, DOWN}.
  - Shared with the car model.
- Sub-module elevator_button_sync: per-bit 2-FF synchronizer plus edge detector, parameterised by width. It is instantiated once with width NUM_FLOORS.

Test Plan:
- Reset, then press floor_button[4] at current_floor=0 -> queue_status=7'b0010000 and request_ack[4] pulse after 3 clk edges; queue_empty 1->0; FSM UP; next_up_ndown=1 one cycle later.
- Pending {1,5}, current_floor=3, current_up_ndown=0 from IDLE -> DOWN, next_up_ndown=0. Set current_floor=1, deassert_floor=1 -> bit1 clears; FSM -> UP, next_up_ndown=1.
- current_floor=2, deassert_floor=1, floor_button[2] edge in the same cycle -> bit2 stays 0, no request_ack[2]; bit set on a later press after deassert_floor drops.
- Hold floor_button[6] high for 50 cycles -> single request_ack[6] pulse; release and re-press -> no new pulse while the bit is still pending.
- Pending {0,3,6}; assert reset_n=0 mid-cycle -> queue_status=0, queue_empty=1, next_up_ndown=1 asynchronously; no requests after reset_n=1 with buttons low.
- Only floor 3 pending at current_floor=3 in UP -> stays UP; deassert_floor clears it -> queue_empty=1, FSM IDLE, next_up_ndown holds 1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Constants and direction-state encoding shared between the request queue and the car model.
package elevator_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_state_t;

endpackage

// File: rtl/elevator_button_sync.sv
// Per-bit two-flop synchronizer for asynchronous call buttons, followed by a rising-edge detector.
module elevator_button_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1_d, sync1_q;
  logic [WIDTH-1:0] sync2_d, sync2_q;
  logic [WIDTH-1:0] prev_d, prev_q;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // prev clears on reset, so a button held through reset release is seen as one fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/elevator_request_queue.sv
// Floor-call request bitmap with LOOK-style service-direction selection for the car controller.
module elevator_request_queue
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] floor_button,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  current_up_ndown,
  input  logic                  deassert_floor,
  output logic [NUM_FLOORS-1:0] queue_status,
  output logic                  queue_empty,
  output logic                  next_up_ndown,
  output logic [NUM_FLOORS-1:0] request_ack
);

  logic [NUM_FLOORS-1:0] rise, clr, above, below;
  logic [NUM_FLOORS-1:0] queue_d, queue_q;
  logic [NUM_FLOORS-1:0] ack_d, ack_q;
  dir_state_t            state_d, state_q;
  logic                  dir_d, dir_q;

  elevator_button_sync #(.WIDTH(NUM_FLOORS)) u_button_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (floor_button),
    .rise     (rise)
  );

  // An out-of-range floor index puts every pending request below the car.
  always_comb begin
    clr   = '0;
    above = '0;
    below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr[i]   = deassert_floor && (int'(current_floor) == i);
      above[i] = queue_q[i] && (i > int'(current_floor));
      below[i] = queue_q[i] && (i < int'(current_floor));
    end
  end

  // Clear beats a simultaneous press; already-pending floors are not re-acknowledged.
  always_comb begin
    queue_d = (queue_q | rise) & ~clr;
    ack_d   = rise & ~queue_q & ~clr;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (above != '0 && (below == '0 || current_up_ndown)) state_d = UP;
        else if (below != '0)                                 state_d = DOWN;
      end
      UP: begin
        if (above != '0)      state_d = UP;
        else if (below != '0) state_d = DOWN;
        else if (queue_empty) state_d = IDLE;
      end
      DOWN: begin
        if (below != '0)      state_d = DOWN;
        else if (above != '0) state_d = UP;
        else if (queue_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dir_d = dir_q;
    if (state_q == UP)        dir_d = 1'b1;
    else if (state_q == DOWN) dir_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      queue_q <= '0;
      ack_q   <= '0;
      state_q <= IDLE;
      dir_q   <= 1'b1;
    end else begin
      queue_q <= queue_d;
      ack_q   <= ack_d;
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  assign queue_status  = queue_q;
  assign queue_empty   = ~|queue_q;
  assign next_up_ndown = dir_q;
  assign request_ack   = ack_q;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for the elevator request queue: button latching, clearing and scan direction.
module tb_elevator_request_queue;
  import elevator_pkg::*;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_FLOORS-1:0] floor_button;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  current_up_ndown;
  logic                  deassert_floor;
  logic [NUM_FLOORS-1:0] queue_status;
  logic                  queue_empty;
  logic                  next_up_ndown;
  logic [NUM_FLOORS-1:0] request_ack;

  int tests_run;
  int tests_failed;
  int cnt;

  elevator_request_queue dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .floor_button     (floor_button),
    .current_floor    (current_floor),
    .current_up_ndown (current_up_ndown),
    .deassert_floor   (deassert_floor),
    .queue_status     (queue_status),
    .queue_empty      (queue_empty),
    .next_up_ndown    (next_up_ndown),
    .request_ack      (request_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the given buttons for three edges (long enough to latch) then release and let the sync drain.
  task automatic press(input logic [NUM_FLOORS-1:0] b);
    floor_button = b;
    repeat (3) tick();
    floor_button = '0;
    repeat (3) tick();
  endtask

  task automatic clear_at(input logic [FLOOR_W-1:0] f);
    current_floor  = f;
    deassert_floor = 1'b1;
    tick();
    deassert_floor = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (queue_status !== 7'b0) begin tests_failed++; $display("FAIL reset_queue got %b exp %b", queue_status, 7'b0); end
    tests_run++;
    if (queue_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b exp 1", queue_empty); end
    tests_run++;
    if (next_up_ndown !== 1'b1) begin tests_failed++; $display("FAIL reset_dir got %b exp 1", next_up_ndown); end
    tests_run++;
    if (request_ack !== 7'b0) begin tests_failed++; $display("FAIL reset_ack got %b exp 0", request_ack); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_first_press();
    current_floor = 3'd0;
    floor_button[4] = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (queue_status !== 7'b0) begin tests_failed++; $display("FAIL press_early got %b exp %b", queue_status, 7'b0); end
    tick();
    tests_run++;
    if (queue_status !== 7'b0010000) begin tests_failed++; $display("FAIL press_queue got %b exp 0010000", queue_status); end
    tests_run++;
    if (request_ack !== 7'b0010000) begin tests_failed++; $display("FAIL press_ack got %b exp 0010000", request_ack); end
    tests_run++;
    if (queue_empty !== 1'b0) begin tests_failed++; $display("FAIL press_empty got %b exp 0", queue_empty); end
    tick();
    tests_run++;
    if (request_ack !== 7'b0) begin tests_failed++; $display("FAIL press_ack_pulse got %b exp 0", request_ack); end
    tests_run++;
    if (dut.state_q !== UP) begin tests_failed++; $display("FAIL press_state got %0d exp %0d", dut.state_q, UP); end
    tick();
    tests_run++;
    if (next_up_ndown !== 1'b1) begin tests_failed++; $display("FAIL press_dir got %b exp 1", next_up_ndown); end
    floor_button = '0;
    repeat (3) tick();
    clear_at(3'd4);
    tick();
    tests_run++;
    if (queue_empty !== 1'b1 || dut.state_q !== IDLE) begin
      tests_failed++; $display("FAIL press_cleanup got empty=%b state=%0d exp empty=1 state=%0d", queue_empty, dut.state_q, IDLE);
    end
  endtask

  task automatic test_direction_change();
    current_floor    = 3'd3;
    current_up_ndown = 1'b0;
    press(7'b0100010);
    tests_run++;
    if (queue_status !== 7'b0100010) begin tests_failed++; $display("FAIL dir_queue got %b exp 0100010", queue_status); end
    tests_run++;
    if (dut.state_q !== DOWN) begin tests_failed++; $display("FAIL dir_state_down got %0d exp %0d", dut.state_q, DOWN); end
    tests_run++;
    if (next_up_ndown !== 1'b0) begin tests_failed++; $display("FAIL dir_next_down got %b exp 0", next_up_ndown); end
    clear_at(3'd1);
    tick();
    tests_run++;
    if (queue_status !== 7'b0100000) begin tests_failed++; $display("FAIL dir_clear1 got %b exp 0100000", queue_status); end
    tests_run++;
    if (dut.state_q !== UP) begin tests_failed++; $display("FAIL dir_state_up got %0d exp %0d", dut.state_q, UP); end
    tests_run++;
    if (next_up_ndown !== 1'b1) begin tests_failed++; $display("FAIL dir_next_up got %b exp 1", next_up_ndown); end
    clear_at(3'd5);
    tick();
    tests_run++;
    if (queue_empty !== 1'b1 || dut.state_q !== IDLE) begin
      tests_failed++; $display("FAIL dir_cleanup got empty=%b state=%0d exp empty=1 state=%0d", queue_empty, dut.state_q, IDLE);
    end
    current_up_ndown = 1'b1;
  endtask

  task automatic test_set_clear_collision();
    current_floor  = 3'd2;
    deassert_floor = 1'b1;
    floor_button[2] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (queue_status[2] !== 1'b0 || request_ack[2] !== 1'b0) cnt++;
    end
    tests_run++;
    if (cnt !== 0) begin tests_failed++; $display("FAIL collision_cycles got %0d bad cycles exp 0", cnt); end
    floor_button = '0;
    deassert_floor = 1'b0;
    repeat (3) tick();
    floor_button[2] = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (queue_status !== 7'b0000100) begin tests_failed++; $display("FAIL collision_repress_queue got %b exp 0000100", queue_status); end
    tests_run++;
    if (request_ack !== 7'b0000100) begin tests_failed++; $display("FAIL collision_repress_ack got %b exp 0000100", request_ack); end
    floor_button = '0;
    repeat (3) tick();
    clear_at(3'd2);
    tick();
    tests_run++;
    if (queue_empty !== 1'b1) begin tests_failed++; $display("FAIL collision_cleanup got %b exp 1", queue_empty); end
  endtask

  task automatic test_hold_button();
    current_floor = 3'd0;
    floor_button[6] = 1'b1;
    cnt = 0;
    repeat (50) begin
      tick();
      if (request_ack[6] === 1'b1) cnt++;
    end
    tests_run++;
    if (cnt !== 1) begin tests_failed++; $display("FAIL hold_pulses got %0d exp 1", cnt); end
    tests_run++;
    if (queue_status !== 7'b1000000) begin tests_failed++; $display("FAIL hold_queue got %b exp 1000000", queue_status); end
    floor_button = '0;
    repeat (3) tick();
    floor_button[6] = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick();
      if (request_ack[6] === 1'b1) cnt++;
    end
    floor_button = '0;
    repeat (3) tick();
    tests_run++;
    if (cnt !== 0) begin tests_failed++; $display("FAIL repress_pending_pulses got %0d exp 0", cnt); end
    tests_run++;
    if (dut.state_q !== UP || next_up_ndown !== 1'b1) begin
      tests_failed++; $display("FAIL hold_dir got state=%0d dir=%b exp state=%0d dir=1", dut.state_q, next_up_ndown, UP);
    end
  endtask

  task automatic test_async_reset();
    current_floor = 3'd0;
    press(7'b0001001);
    tests_run++;
    if (queue_status !== 7'b1001001) begin tests_failed++; $display("FAIL areset_pending got %b exp 1001001", queue_status); end
    current_floor = 3'd7;
    repeat (3) tick();
    tests_run++;
    if (dut.state_q !== DOWN || next_up_ndown !== 1'b0) begin
      tests_failed++; $display("FAIL out_of_range_dir got state=%0d dir=%b exp state=%0d dir=0", dut.state_q, next_up_ndown, DOWN);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (queue_status !== 7'b0 || queue_empty !== 1'b1) begin
      tests_failed++; $display("FAIL areset_queue got %b empty=%b exp 0000000 empty=1", queue_status, queue_empty);
    end
    tests_run++;
    if (next_up_ndown !== 1'b1 || dut.state_q !== IDLE) begin
      tests_failed++; $display("FAIL areset_dir got dir=%b state=%0d exp dir=1 state=%0d", next_up_ndown, dut.state_q, IDLE);
    end
    tick();
    reset_n = 1'b1;
    current_floor = 3'd0;
    cnt = 0;
    repeat (6) begin
      tick();
      if (request_ack !== 7'b0) cnt++;
    end
    tests_run++;
    if (queue_status !== 7'b0 || cnt !== 0) begin
      tests_failed++; $display("FAIL areset_no_requests got %b acks=%0d exp 0000000 acks=0", queue_status, cnt);
    end
    floor_button[5] = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick();
      if (request_ack[5] === 1'b1) cnt++;
    end
    tests_run++;
    if (queue_status !== 7'b0100000 || cnt !== 1) begin
      tests_failed++; $display("FAIL held_through_reset got %b acks=%0d exp 0100000 acks=1", queue_status, cnt);
    end
    floor_button = '0;
    repeat (3) tick();
    clear_at(3'd5);
    tick();
  endtask

  task automatic test_current_floor_only();
    current_floor = 3'd2;
    press(7'b0001000);
    current_floor = 3'd3;
    repeat (3) tick();
    tests_run++;
    if (dut.state_q !== UP || queue_status !== 7'b0001000) begin
      tests_failed++; $display("FAIL cur_only_up got state=%0d q=%b exp state=%0d q=0001000", dut.state_q, queue_status, UP);
    end
    clear_at(3'd3);
    tests_run++;
    if (queue_empty !== 1'b1) begin tests_failed++; $display("FAIL cur_only_clear got %b exp 1", queue_empty); end
    tick();
    tests_run++;
    if (dut.state_q !== IDLE || next_up_ndown !== 1'b1) begin
      tests_failed++; $display("FAIL cur_only_idle_up got state=%0d dir=%b exp state=%0d dir=1", dut.state_q, next_up_ndown, IDLE);
    end
    current_floor = 3'd5;
    press(7'b0001000);
    tests_run++;
    if (dut.state_q !== DOWN || next_up_ndown !== 1'b0) begin
      tests_failed++; $display("FAIL cur_only_down got state=%0d dir=%b exp state=%0d dir=0", dut.state_q, next_up_ndown, DOWN);
    end
    clear_at(3'd3);
    repeat (2) tick();
    tests_run++;
    if (dut.state_q !== IDLE || next_up_ndown !== 1'b0) begin
      tests_failed++; $display("FAIL cur_only_idle_hold got state=%0d dir=%b exp state=%0d dir=0", dut.state_q, next_up_ndown, IDLE);
    end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    cnt              = 0;
    reset_n          = 1'b0;
    floor_button     = '0;
    current_floor    = '0;
    current_up_ndown = 1'b1;
    deassert_floor   = 1'b0;
    test_reset();
    test_first_press();
    test_direction_change();
    test_set_clear_collision();
    test_hold_button();
    test_async_reset();
    test_current_floor_only();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
